// File: rtl/register_file_8x16.sv
// register_file_8x16: 8x16 register file, two async read ports, one sync write port at address_a
module register_file_8x16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b
);
  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (!rst_n) regs <= '{default: '0};
    else if (write_enable) regs[address_a] <= write_data;
  assign data_a = regs[address_a];
  assign data_b = regs[address_b];
endmodule

// File: tb/tb_register_file_8x16.sv
// tb_register_file_8x16: scoreboard bench for register_file_8x16 against an array model
module tb_register_file_8x16;
  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] ea;
    logic [15:0] eb;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [2:0]  address_a = 0;
  logic [2:0]  address_b = 0;
  logic        write_enable = 0;
  logic [15:0] write_data = 0;
  logic [15:0] data_a, data_b;
  logic [15:0] model [8];
  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  register_file_8x16 dut (
    .clk(clk), .rst_n(rst_n), .address_a(address_a), .address_b(address_b),
    .write_enable(write_enable), .write_data(write_data), .data_a(data_a), .data_b(data_b)
  );

  initial forever #5 clk = ~clk;

  // Each expectation holds the contents visible before the upcoming edge, so writes are read-old.
  task automatic step(input logic r, input logic w, input logic [15:0] d,
                      input logic [2:0] a, input logic [2:0] b, input bit chk);
    @(posedge clk);
    #1;
    rst_n = r; write_enable = w; write_data = d; address_a = a; address_b = b;
    if (chk) q.push_back('{a: a, b: b, ea: model[a], eb: model[b]});
    if (!r) model = '{default: 16'h0000};
    else if (w) model[a] = d;
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks += 2;
      if (data_a !== e.ea) begin
        n_fail++;
        $display("FAIL data_a addr=%0d got=%h expected=%h", e.a, data_a, e.ea);
      end
      if (data_b !== e.eb) begin
        n_fail++;
        $display("FAIL data_b addr=%0d got=%h expected=%h", e.b, data_b, e.eb);
      end
    end
  end

  initial begin
    int budget;
    model = '{default: 16'h0000};
    step(0, 1, 16'hFFFF, 3, 3, 0);
    step(0, 1, 16'hFFFF, 3, 3, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 16'h0000, 3'(i), 3'(7 - i), 1);
    step(1, 1, 16'h0005, 1, 0, 1);
    step(1, 1, 16'h0007, 2, 0, 1);
    step(1, 0, 16'h0000, 1, 2, 1);
    step(1, 1, 16'hABCD, 4, 4, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 16'h0000, 4, 4, 1);
    step(1, 0, 16'h0000, 3, 1, 1);
    step(1, 0, 16'h0000, 1, 2, 1);
    step(1, 1, 16'h000C, 3, 1, 1);
    step(1, 0, 16'h0000, 3, 2, 1);
    step(1, 0, 16'h0000, 1, 2, 1);
    step(1, 1, 16'h1111, 7, 7, 1);
    step(1, 1, 16'h2222, 7, 7, 1);
    step(1, 0, 16'h0000, 7, 7, 1);
    step(0, 1, 16'h5555, 7, 7, 1);
    step(1, 0, 16'h0000, 7, 4, 1);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) != 0), 1'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), 1);
    step(1, 0, 16'h0000, 0, 0, 0);
    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
